// File: rtl/dshot_frame_rx.sv
// DShot150 frame receiver: measures pulse widths on the synchronized line,
// assembles 16-bit frames, verifies the 4-bit CRC and publishes throttle/telemetry.
module dshot_frame_rx #(
  parameter int BIT_THRESH   = 60,
  parameter int MIN_HIGH     = 10,
  parameter int MAX_HIGH     = 100,
  parameter int IDLE_TIMEOUT = 200,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dshotPin,
  output logic [10:0] throttle,
  output logic        telemetry,
  output logic        frame_valid,
  output logic        crc_error,
  output logic        frame_abort,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for the first rising edge of a frame
  // HIGH  | measuring the high time of the current bit
  // LOW   | measuring the low gap between bits
  // CHECK | full frame captured, CRC compared this cycle
  typedef enum logic [1:0] {IDLE, HIGH, LOW, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_HIGH_C = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(IDLE_TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [15:0]      shreg, shreg_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic             valid_set, err_set, abort_set;
  logic             sync1, sync2, line_d;
  logic             rise, fall;
  logic [11:0]      frame_v;
  logic [3:0]       crc_calc;

  // Synchronizer flops are left free-running so a line already high at reset
  // release is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    sync1  <= dshotPin;
    sync2  <= sync1;
    line_d <= sync2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= sync2 & ~line_d;
      fall <= ~sync2 & line_d;
    end
  end

  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign frame_v  = shreg[15:4];
  assign crc_calc = frame_v[3:0] ^ frame_v[7:4] ^ frame_v[11:8];

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    valid_set   = 1'b0;
    err_set     = 1'b0;
    abort_set   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          cnt_nxt   = '0;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          if (cnt < MIN_HIGH_C) begin
            abort_set   = 1'b1;
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            shreg_nxt   = {shreg[14:0], (cnt >= THRESH_C)};
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state_nxt = CHECK;
            end else begin
              cnt_nxt   = '0;
              state_nxt = LOW;
            end
          end
        end else if (cnt > MAX_HIGH_C) begin
          abort_set   = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      LOW: begin
        if (rise) begin
          cnt_nxt   = '0;
          state_nxt = HIGH;
        end else if (cnt >= TIMEOUT_C) begin
          abort_set   = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      CHECK: begin
        if (crc_calc == shreg[3:0]) valid_set = 1'b1;
        else                        err_set   = 1'b1;
        bit_cnt_nxt = '0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      throttle    <= '0;
      telemetry   <= 1'b0;
      frame_valid <= 1'b0;
      crc_error   <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= valid_set;
      crc_error   <= err_set;
      frame_abort <= abort_set;
      busy        <= (state_nxt != IDLE);
      if (valid_set) begin
        throttle  <= frame_v[11:1];
        telemetry <= frame_v[0];
      end
    end
  end

endmodule

// File: doc/dshot_frame_rx.md
Name: dshot_frame_rx

Overview:
Receives the raw DShot150 serial line and recovers each 16-bit frame from its pulse widths. Each frame carries an 11-bit throttle, 1 telemetry bit and a 4-bit CRC. The block checks the CRC and publishes validated throttle and telemetry with a one-cycle strobe. It sits directly upstream of the speed handler, which maps throttle to the 8-bit target speed for the PWM output stage. Timing is sized for the 16 MHz board clock, where one DShot150 bit is about 107 cycles.

Parameters:
BIT_THRESH, 60, high-time cycle count at or above which a bit decodes as 1.
MIN_HIGH, 10, high pulses shorter than this are glitches; they abort the frame.
MAX_HIGH, 100, a high pulse longer than this aborts the frame (line stuck high).
IDLE_TIMEOUT, 200, low-time cycle count that aborts a partially received frame.
CNT_W, 8, width of the pulse counter; it saturates at 2^CNT_W-1, and every parameter must be below that value.

Ports:
clk  input  1  system clock, 16 MHz
rst  input  1  synchronous reset, active-high
dshotPin  input  1  raw asynchronous DShot line
throttle  output  11  last CRC-valid throttle value
telemetry  output  1  last CRC-valid telemetry request bit
frame_valid  output  1  one-cycle pulse when throttle/telemetry update
crc_error  output  1  one-cycle pulse when a complete frame fails CRC
frame_abort  output  1  one-cycle pulse when a partial frame is discarded
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Clocking and reset: one clock domain (clk); reset is synchronous and active-high on rst.
- Input path: dshotPin passes through a 2-flop synchronizer, then a third flop for edge detection. All timing below refers to the synchronized signal.
- Reset values: throttle=0, telemetry=0, all pulse outputs=0, busy=0. Shift register, bit counter and pulse counter are cleared; state=IDLE.
- Reset mid-frame: the partial frame is discarded with no pulse. If the line is high when reset releases, the following falling edge is ignored, because IDLE accepts only a rising edge.
- State IDLE: on a rising edge, clear the pulse counter and go to HIGH. Falling edges are ignored.
- State HIGH: pulse counter increments each cycle. On a falling edge:
  - If count < MIN_HIGH, pulse frame_abort and go to IDLE.
  - Otherwise, shift bit = (count >= BIT_THRESH) into the LSB of a 16-bit register (MSB first on the wire) and increment the bit counter.
  - After the 16th bit, go to CHECK; otherwise clear the counter and go to LOW.
  - If count exceeds MAX_HIGH while still high, pulse frame_abort and go to IDLE.
- State LOW: counter increments. On a rising edge, clear the counter and go to HIGH. If count reaches IDLE_TIMEOUT, pulse frame_abort and go to IDLE.
- State CHECK (one cycle):
  - Split the frame: v = frame[15:4], rx_crc = frame[3:0].
  - Compute crc = (v ^ (v>>4) ^ (v>>8)) & 4'hF.
  - On match, next cycle: throttle = v[11:1], telemetry = v[0], frame_valid = 1.
  - On mismatch, next cycle: crc_error = 1 and outputs hold.
  - Bit counter clears; state returns to IDLE.
- Latency: frame_valid or crc_error asserts 5 clk edges after the raw falling edge of bit 15. Breakdown: 2 synchronizer edges, 1 edge-detect edge, 1 edge into CHECK, 1 output edge.
- Outputs are registered, and throttle/telemetry change only in the cycle frame_valid is high.
- A throttle value of 0 is a valid frame.
- At most one pulse output is high in any cycle.
- Back-to-back frames: IDLE is re-entered before the next frame's first rising edge can arrive (minimum bit low time exceeds 3 cycles), so no frame is lost.

Test Plan:
- Bit encoding used throughout: "1" = 80 cycles high / 27 low; "0" = 40 cycles high / 67 low.
- Frame 16'h82C6 -> exactly one frame_valid pulse, throttle=1046, telemetry=0, crc_error=0; pulse arrives 5 edges after the last raw falling edge.
- Frame 16'h82C7 (bad CRC) after scenario 1 -> one crc_error pulse, no frame_valid, throttle stays 1046.
- 8 valid bits, then line held low 250 cycles -> frame_abort pulse at low count 200, busy falls; a following 16'h0011 frame decodes throttle=0, telemetry=1.
- 5-cycle high glitch mid-frame -> frame_abort. Line held high 150 cycles -> frame_abort when the count passes 100.
- Two valid frames separated by 214 low cycles -> two frame_valid pulses with the correct values.
- rst asserted for one cycle during bit 9 -> no pulse, busy=0, outputs cleared; the next full frame decodes correctly.
